uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO that feeds a UART transmitter with one-cycle start pulses.
// Optional sticky drop flag o_overflow is built when UART_TX_OVERFLOW_EN is defined.
module uart_tx_feeder #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_wr_en,
    input  logic [DATA_W-1:0]      i_wr_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_tx_start,
    output logic [DATA_W-1:0]      o_tx_data,
    input  logic                   i_tx_busy
`ifdef UART_TX_OVERFLOW_EN
    ,
    output logic                   o_overflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic                r_full;
    logic                r_empty;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic [3:0]          r_timeout;

    logic                w_pop;
    logic                w_push;
    logic                w_timeout_inc;

    // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
    assign w_push = i_wr_en && (!r_full || w_pop);

    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_timeout_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && !i_tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // A transmitter that never raises busy still consumes the byte after 16 idle cycles.
                if (i_tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_timeout == 4'd15) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_timeout_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || r_state != S_WAIT_BUSY) begin
            r_timeout <= 4'd0;
        end else if (w_timeout_inc) begin
            r_timeout <= r_timeout + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset && w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef UART_TX_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (i_wr_en && r_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;
`endif

    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - randomized self-checking bench for uart_tx_feeder against a queue model.
module tb_uart_tx_feeder;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              tx_busy;
    logic              full;
    logic              empty;
    logic [3:0]        count;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
`ifdef UART_TX_OVERFLOW_EN
    logic              overflow;
`endif

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .i_tx_busy  (tx_busy)
`ifdef UART_TX_OVERFLOW_EN
        ,
        .o_overflow (overflow)
`endif
    );

    // Reference: byte queue plus a "link free" flag describing when the transmitter may take a byte.
    logic [DATA_W-1:0] q[$];
    bit                m_free;
    bit                m_seen;
    int                m_wcnt;
    bit                m_start;
    logic [DATA_W-1:0] m_data;
    bit                m_ovf;

    int n_pass   = 0;
    int n_checks = 0;

    bit force_busy = 1'b0;
    int xmit_len   = 20;
    int xmit_rem   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input bit rst_i, input bit wr_i, input logic [DATA_W-1:0] d_i);
        bit busy_i;
        bit pop;
        bit acc;
        busy_i  = force_busy || (xmit_rem > 0);
        rst     = rst_i;
        wr_en   = wr_i;
        wr_data = d_i;
        tx_busy = busy_i;
        @(posedge clk);
        if (rst_i) begin
            q.delete();
            m_free  = 1'b1;
            m_seen  = 1'b0;
            m_wcnt  = 0;
            m_start = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
        end else begin
            pop = m_free && (q.size() > 0) && !busy_i;
            acc = wr_i && ((q.size() < DEPTH) || pop);
            if (wr_i && !acc) m_ovf = 1'b1;
            m_start = pop;
            if (pop) begin
                m_data = q.pop_front();
                m_free = 1'b0;
                m_seen = 1'b0;
                m_wcnt = 0;
            end else if (!m_free) begin
                if (m_seen) begin
                    if (!busy_i) m_free = 1'b1;
                end else if (busy_i) begin
                    m_seen = 1'b1;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == 16) m_free = 1'b1;
                end
            end
            if (acc) q.push_back(d_i);
        end
        #1;
        check("tx_start", tx_start, m_start);
        check("tx_data", tx_data, m_data);
        check("count", count, q.size());
        check("full", full, (q.size() == DEPTH));
        check("empty", empty, (q.size() == 0));
`ifdef UART_TX_OVERFLOW_EN
        check("overflow", overflow, m_ovf);
`endif
        if (xmit_rem > 0) xmit_rem--;
        if (tx_start && xmit_len > 0) xmit_rem = xmit_len;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    initial begin
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 8'hAA);
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);

        tick(1'b0, 1'b1, 8'hCB);
        tick(1'b0, 1'b0, '0);
        check("first_pulse", tx_start, 1);
        check("first_data", tx_data, 8'hCB);
        idle(40);

        tick(1'b0, 1'b1, 8'hCB);
        tick(1'b0, 1'b1, 8'h93);
        tick(1'b0, 1'b1, 8'h68);
        idle(90);

        force_busy = 1'b1;
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 8'($urandom));
        check("full_after9", full, 1);
        check("count_after9", count, 8);
        force_busy = 1'b0;
        idle(220);

        xmit_len = 0;
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'h22);
        idle(60);
        xmit_len = 20;

        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'(8'h30 + i));
        idle(5);
        tick(1'b1, 1'b0, '0);
        check("rst_mid_count", count, 0);
        check("rst_mid_empty", empty, 1);
        idle(30);

        force_busy = 1'b1;
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'(8'hA0 + i));
        for (int i = 0; i < 40 && xmit_rem > 0; i++) tick(1'b0, 1'b0, '0);
        force_busy = 1'b0;
        tick(1'b0, 1'b1, 8'h55);
        check("coincide_count", count, 8);
        idle(250);

        for (int blk = 0; blk < 30; blk++) begin
            xmit_len   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 24);
            force_busy = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 399) == 0) begin
                    tick(1'b1, 1'($urandom), 8'($urandom));
                end else begin
                    tick(1'b0, 1'($urandom_range(0, 2) == 0), 8'($urandom));
                end
                if (i == 60) force_busy = 1'b0;
            end
        end
        idle(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
